// File: rtl/apb_master_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_pkg
// Shared types and constants for the APB requester that drives the I2C
// bridge register block.
//   apb_state_t      : requester FSM states
//   ADDR_*           : register map of the I2C bridge completer
// ---------------------------------------------------------------------------
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam logic [31:0] ADDR_TX_FIFO     = 32'h0000_0000;
  localparam logic [31:0] ADDR_RX_FIFO     = 32'h0000_0004;
  localparam logic [31:0] ADDR_I2C_CONFIG  = 32'h0000_0008;
  localparam logic [31:0] ADDR_I2C_TIMEOUT = 32'h0000_000C;

endpackage

// File: rtl/apb_watchdog.sv
// ---------------------------------------------------------------------------
// apb_watchdog
// Saturating cycle counter that flags a completer which keeps PREADY low
// for too long.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   clear   : zero the counter (asserted the cycle before ACCESS)
//   enable  : count this cycle (asserted during ACCESS)
//   expire  : this enabled cycle is the TIMEOUT_CYCLES-th one (or later)
// TIMEOUT_CYCLES = 0 removes the counter and ties expire low.
// ---------------------------------------------------------------------------
module apb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled

    logic unused_inputs;
    assign unused_inputs = clk ^ rst ^ clear ^ enable;
    assign expire        = 1'b0;

  end else begin : g_enabled

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Counter saturates at LIMIT so a long stall can never wrap it back
    // below the expiry threshold.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable && (count != LIMIT)) begin
        count <= count + 1'b1;
      end
    end

    // Expire fires during the cycle whose closing edge brings the count to
    // TIMEOUT_CYCLES, so the abort lands after exactly that many ACCESS
    // cycles.
    assign expire = enable && (count >= LAST);

  end

endmodule

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB3 requester: accepts one command at a time, runs it as a SETUP/ACCESS
// transfer and returns the result on a response channel. A watchdog aborts
// transfers whose completer never raises PREADY.
//   PCLK, PRESET                 : clock, asynchronous active-high reset
//   CMD_VALID/READY/WRITE/ADDR/WDATA : command channel
//   RSP_VALID/READY/RDATA/ERR/TIMEOUT : response channel
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : APB request signals
//   PRDATA/PREADY/PSLVERR        : APB completer signals
// ---------------------------------------------------------------------------
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_TIMEOUT,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_t state;
  apb_state_t next_state;
  logic       accept;
  logic       wd_expire;

  assign accept = (state == IDLE) && CMD_VALID;

  // State register. Bus-facing strobes are decoded from this register, so
  // the asynchronous reset drops PSEL/PENABLE/RSP_VALID without a clock.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode. PREADY is checked before the watchdog so
  // a completion on the expiry edge is treated as a normal completion.
  always_comb begin
    next_state = state;
    CMD_READY  = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    RSP_VALID  = 1'b0;
    case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) next_state = SETUP;
      end
      SETUP: begin
        PSEL       = 1'b1;
        next_state = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || wd_expire) next_state = RESP;
      end
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured only at command acceptance and then held,
  // so later changes on the command inputs cannot disturb the bus.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= CMD_WRITE;
      PADDR  <= CMD_ADDR;
      PWDATA <= CMD_WDATA;
    end
  end

  // Response registers load once, on the edge that leaves ACCESS, and stay
  // stable through RESP until the consumer takes them.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else if (state == ACCESS) begin
      if (PREADY) begin
        RSP_RDATA   <= PWRITE ? '0 : PRDATA;
        RSP_ERR     <= PSLVERR;
        RSP_TIMEOUT <= 1'b0;
      end else if (wd_expire) begin
        RSP_RDATA   <= '0;
        RSP_ERR     <= 1'b1;
        RSP_TIMEOUT <= 1'b1;
      end
    end
  end

  apb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (PCLK),
    .rst   (PRESET),
    .clear (state == SETUP),
    .enable(state == ACCESS),
    .expire(wd_expire)
  );

endmodule

// File: doc/apb_master.md
# apb_master

Parameterised APB3 requester that turns single-beat command requests from an internal controller into APB transfers, and returns read data and error status on a response channel. It drives the peripheral-side APB bus of the I2C bridge: writes to address 0x0 push the TX FIFO, reads from 0x4 pop the RX FIFO, and writes to 0x8/0xC load the configuration and timeout registers. A PREADY watchdog guarantees that a hung completer cannot stall the controller.

## Interface
- ADDR_W, 32, PADDR and CMD_ADDR width
- DATA_W, 32, PWDATA/PRDATA/CMD_WDATA/RSP_RDATA width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the watchdog
- PCLK  in  1  single clock, all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- CMD_VALID  in  1  command present
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY at a rising edge
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADDR_W  target address
- CMD_WDATA  in  DATA_W  write data, ignored for reads
- RSP_VALID  out  1  response present
- RSP_READY  in  1  response consumed when RSP_VALID & RSP_READY at a rising edge
- RSP_RDATA  out  DATA_W  read data; 0 for writes and for timeouts
- RSP_ERR  out  1  PSLVERR sampled at completion, or 1 on timeout
- RSP_TIMEOUT  out  1  transfer aborted by watchdog
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: CMD_READY=1. On handshake, register CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA, then go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Always lasts exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Watchdog counter increments each cycle.
  - PREADY=1 at an edge: capture PRDATA (reads only, else 0) and PSLVERR into the response registers. RSP_TIMEOUT=0. Go to RESP.
  - Counter reaches TIMEOUT_CYCLES with PREADY=0: RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0. Go to RESP.
  - If PREADY arrives on the same edge as the timeout, PREADY wins.
- RESP: PSEL=0, PENABLE=0, RSP_VALID=1. Response fields are stable until the handshake, then go to IDLE.
- PADDR/PWRITE/PWDATA hold their last value outside transfers and change only at command acceptance.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to ACCESS and saturates, never wraps.
- Only one transfer is outstanding at a time; there is no command buffering.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT all 0; CMD_READY=1; state IDLE.
- Minimum latency: command accepted at edge N, SETUP in cycle N+1, ACCESS in cycle N+2. With PREADY=1 in ACCESS, RSP_VALID=1 in cycle N+3.
- Wait states: each PREADY=0 cycle in ACCESS adds one cycle of latency.
- Maximum throughput is one transfer per 4 cycles (IDLE→SETUP→ACCESS→RESP→IDLE) with RSP_READY tied high.
- PRESET asserted mid-transfer drops PSEL/PENABLE/RSP_VALID immediately, without waiting for a clock edge. The in-flight command is discarded and no response is produced.
- Inputs CMD_* are sampled only at acceptance; later changes have no effect.

## Structure
- Package apb_master_pkg:
  - state enum apb_state_t {IDLE, SETUP, ACCESS, RESP}
  - address constants ADDR_TX_FIFO=0x0, ADDR_RX_FIFO=0x4, ADDR_I2C_CONFIG=0x8, ADDR_I2C_TIMEOUT=0xC
- One sub-module, apb_watchdog: saturating counter with clear, enable and expire output, parameterised by TIMEOUT_CYCLES, tied to 0 when disabled.

## Test plan
- Write 0xDEAD_BEEF to 0x8, PREADY tied 1 → SETUP/ACCESS one cycle each with PADDR=0x8, PWRITE=1; RSP_VALID 3 cycles after accept; RSP_ERR=0; RSP_RDATA=0.
- Read 0x4 with PREADY low for 3 ACCESS cycles, PRDATA=0x0000_00A5 on the ready cycle → PENABLE high for 4 cycles; RSP_RDATA=0xA5; PSEL/PENABLE never drop inside the transfer.
- Read 0x10 where the completer returns PSLVERR=1 with PREADY → RSP_ERR=1, RSP_TIMEOUT=0.
- TIMEOUT_CYCLES=16, PREADY stuck 0 → abort after 16 ACCESS cycles; RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0. Then PREADY=1 on exactly the 16th cycle → normal completion.
- RSP_READY held low for 5 cycles with CMD_VALID high → CMD_READY=0, response stable throughout, next command accepted the cycle after the response handshake.
- PRESET pulsed during ACCESS → PSEL/PENABLE low asynchronously, all outputs at reset values, no RSP_VALID; the next command proceeds normally.
